// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {npc, ins} pairs with
// valid/ready pop, full backpressure, flush-on-branch and a sticky overflow flag.
module if_id_queue #(
  parameter int unsigned          bus_width = 32,
  parameter int unsigned          depth     = 4,
  parameter logic [bus_width-1:0] nop_word  = '0
) (
  input  logic                   clock,
  input  logic                   reset_n_in,
  input  logic [bus_width-1:0]   ins_in,
  input  logic [bus_width-1:0]   npc_in,
  input  logic                   fetch_valid_in,
  output logic                   wait_for_next_out,
  input  logic                   flush_in,
  input  logic                   freeze_in,
  input  logic                   decode_ready_in,
  output logic                   valid_out,
  output logic [bus_width-1:0]   ins_out,
  output logic [bus_width-1:0]   npc_out,
  output logic [$clog2(depth):0] count_out,
  output logic                   overflow_err_out
);

  localparam int unsigned    PW       = $clog2(depth);
  localparam int unsigned    CW       = PW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(depth);

  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic [bus_width-1:0] ins_mem_q [depth];
  logic [bus_width-1:0] npc_mem_q [depth];
  logic                 full, empty, push, pop;

  // Push/pop are decided from the registered count only, so a pop never frees
  // a slot for a push in the same cycle.
  always_comb begin
    full     = (count_q == FULL_CNT);
    empty    = (count_q == '0);
    push     = fetch_valid_in && !full;
    pop      = !empty && decode_ready_in && !freeze_in;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (fetch_valid_in & full);
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clock) begin
    if (reset_n_in && !flush_in && push) begin
      ins_mem_q[wr_ptr_q] <= ins_in;
      npc_mem_q[wr_ptr_q] <= npc_in;
    end
  end

  assign valid_out         = !empty;
  assign ins_out           = empty ? nop_word : ins_mem_q[rd_ptr_q];
  assign npc_out           = empty ? '0 : npc_mem_q[rd_ptr_q];
  assign count_out         = count_q;
  assign wait_for_next_out = full;
  assign overflow_err_out  = ovf_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table plus a random phase, with a
// queue model that tracks the expected head entry, occupancy and overflow flag.
module tb_if_id_queue;

  localparam int unsigned BW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] NOP = 32'hDEAD_BEEF;

  logic          clock = 1'b0;
  logic          reset_n_in;
  logic [BW-1:0] ins_in, npc_in;
  logic          fetch_valid_in, flush_in, freeze_in, decode_ready_in;
  logic          wait_for_next_out, valid_out, overflow_err_out;
  logic [BW-1:0] ins_out, npc_out;
  logic [CW-1:0] count_out;

  if_id_queue #(.bus_width(BW), .depth(DEPTH), .nop_word(NOP)) dut (
    .clock(clock), .reset_n_in(reset_n_in), .ins_in(ins_in), .npc_in(npc_in),
    .fetch_valid_in(fetch_valid_in), .wait_for_next_out(wait_for_next_out),
    .flush_in(flush_in), .freeze_in(freeze_in), .decode_ready_in(decode_ready_in),
    .valid_out(valid_out), .ins_out(ins_out), .npc_out(npc_out),
    .count_out(count_out), .overflow_err_out(overflow_err_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          rst;
    logic          fv;
    logic [BW-1:0] ins;
    logic [BW-1:0] npc;
    logic          fl, fz, rdy;
    int            exp_cnt;
    logic          exp_wait;
    logic          exp_ovf;
  } vec_t;

  vec_t        tbl[$];
  logic [63:0] sb_q[$];   // {npc, ins}
  logic        m_ovf;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic fv, input logic [BW-1:0] ins,
                     input logic [BW-1:0] npc, input logic fl, input logic fz,
                     input logic rdy, input int cnt, input logic w, input logic o);
    vec_t v;
    v.rst = rst; v.fv = fv; v.ins = ins; v.npc = npc; v.fl = fl; v.fz = fz;
    v.rdy = rdy; v.exp_cnt = cnt; v.exp_wait = w; v.exp_ovf = o;
    tbl.push_back(v);
  endtask

  // Drive one cycle: check head state against the model before the edge,
  // advance the model, then let the edge happen.
  task automatic step(input vec_t v);
    logic        m_valid, m_full, m_pop;
    logic [63:0] head;
    @(negedge clock);
    reset_n_in      = !v.rst;
    fetch_valid_in  = v.fv;
    ins_in          = v.ins;
    npc_in          = v.npc;
    flush_in        = v.fl;
    freeze_in       = v.fz;
    decode_ready_in = v.rdy;
    #1;
    m_valid = (sb_q.size() != 0);
    head    = m_valid ? sb_q[0] : {32'h0, NOP};
    chk("count", 64'(count_out), 64'(sb_q.size()));
    chk("valid", 64'(valid_out), 64'(m_valid));
    chk("head_ins", 64'(ins_out), 64'(head[31:0]));
    chk("head_npc", 64'(npc_out), 64'(head[63:32]));
    chk("wait", 64'(wait_for_next_out), 64'(sb_q.size() == DEPTH));
    chk("ovf", 64'(overflow_err_out), 64'(m_ovf));
    if (v.rst) begin
      sb_q.delete();
      m_ovf = 1'b0;
    end else begin
      m_full = (sb_q.size() == DEPTH);
      m_pop  = m_valid && v.rdy && !v.fz;
      if (v.fv && m_full) m_ovf = 1'b1;
      if (v.fl) sb_q.delete();
      else begin
        if (m_pop) void'(sb_q.pop_front());
        if (v.fv && !m_full) sb_q.push_back({v.npc, v.ins});
      end
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n_in = 1'b0; fetch_valid_in = 1'b0; flush_in = 1'b0; freeze_in = 1'b0;
    decode_ready_in = 1'b0; ins_in = '0; npc_in = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    //  rst fv  ins            npc        fl fz rdy  cnt wait ovf
    add(1, 0, 32'h0,          32'h0,     0, 0, 0,   0, 0, 0);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 0);  // idle, ready ignored
    add(0, 1, 32'h11,         32'h1,     0, 0, 0,   1, 0, 0);
    add(0, 1, 32'h22,         32'h2,     0, 0, 0,   2, 0, 0);
    add(0, 1, 32'h33,         32'h3,     0, 0, 0,   3, 0, 0);
    add(0, 1, 32'h44,         32'h4,     0, 0, 0,   4, 1, 0);
    add(0, 1, 32'h55,         32'h5,     0, 0, 0,   4, 1, 1);  // overflow
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   3, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   2, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   1, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 1);
    add(0, 1, 32'hA1,         32'h101,   0, 0, 0,   1, 0, 1);
    add(0, 1, 32'hA2,         32'h102,   0, 0, 0,   2, 0, 1);
    for (int i = 3; i <= 8; i++)
      add(0, 1, 32'hA0 + BW'(i), 32'h100 + BW'(i), 0, 0, 1, 2, 0, 1);  // wraps pointers
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   1, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 1);
    add(0, 1, 32'hB1,         32'h201,   0, 0, 0,   1, 0, 1);
    add(0, 1, 32'hB2,         32'h202,   0, 0, 0,   2, 0, 1);
    add(0, 1, 32'hB3,         32'h203,   0, 0, 0,   3, 0, 1);
    add(0, 1, 32'hB4,         32'h204,   1, 0, 1,   0, 0, 1);  // flush beats push+pop
    add(0, 1, 32'hC1,         32'h301,   0, 0, 0,   1, 0, 1);
    add(0, 1, 32'hC2,         32'h302,   0, 1, 1,   2, 0, 1);  // freeze holds head
    add(0, 1, 32'hC3,         32'h303,   0, 0, 0,   3, 0, 1);
    add(1, 1, 32'hC4,         32'h304,   0, 0, 1,   0, 0, 0);  // reset mid-operation
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 0);
    add(0, 1, 32'hD1,         32'h401,   0, 0, 0,   1, 0, 0);
    add(0, 1, 32'hD2,         32'h402,   0, 0, 0,   2, 0, 0);
    add(0, 1, 32'hD3,         32'h403,   0, 0, 0,   3, 0, 0);
    add(0, 1, 32'hD4,         32'h404,   0, 0, 0,   4, 1, 0);
    add(0, 1, 32'hD5,         32'h405,   0, 0, 1,   3, 0, 1);  // full: pop, push dropped
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   2, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   1, 0, 1);
    add(0, 0, 32'h0,          32'h0,     0, 0, 1,   0, 0, 1);

    foreach (tbl[i]) begin
      step(tbl[i]);
      chk($sformatf("vec%0d_count", i), 64'(count_out), 64'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_wait", i), 64'(wait_for_next_out), 64'(tbl[i].exp_wait));
      chk($sformatf("vec%0d_ovf", i), 64'(overflow_err_out), 64'(tbl[i].exp_ovf));
    end

    for (int i = 0; i < 400; i++) begin
      vec_t r;
      r.rst = ($urandom_range(0, 59) == 0);
      r.fv  = ($urandom_range(0, 2) != 0);
      r.ins = $urandom;
      r.npc = $urandom;
      r.fl  = ($urandom_range(0, 19) == 0);
      r.fz  = ($urandom_range(0, 3) == 0);
      r.rdy = ($urandom_range(0, 2) != 0);
      r.exp_cnt = 0; r.exp_wait = 1'b0; r.exp_ovf = 1'b0;
      step(r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
